// File: rtl/clk_freq_meter_if.sv
// Measurement interface of clk_freq_meter: enable and signal in, gated frequency
// and period results out. Widths must match the meter's parameters.
interface clk_freq_meter_if #(
    parameter int COUNT_W   = 16,
    parameter int PERIOD_W  = 24,
    parameter int GATE_RATE = 1000
);
    localparam int HZ_W = COUNT_W + $clog2(GATE_RATE + 1);

    logic                en;
    logic                sig_in;
    logic [COUNT_W-1:0]  freq_count;
    logic [HZ_W-1:0]     freq_hz;
    logic                freq_valid;
    logic                freq_ovf;
    logic [PERIOD_W-1:0] period_cycles;
    logic                period_valid;
    logic                signal_lost;

    modport master (
        output en, sig_in,
        input  freq_count, freq_hz, freq_valid, freq_ovf,
        input  period_cycles, period_valid, signal_lost
    );

    modport slave (
        input  en, sig_in,
        output freq_count, freq_hz, freq_valid, freq_ovf,
        output period_cycles, period_valid, signal_lost
    );
endinterface

// File: rtl/clk_freq_meter.sv
// Clock/strobe meter: counts synchronized rising edges of sig_in per fixed gate window
// and measures the last input period in clk_in cycles, flagging loss of signal.
module clk_freq_meter #(
    parameter int REF_FREQ  = 50000000,
    parameter int GATE_RATE = 1000,
    parameter int COUNT_W   = 16,
    parameter int PERIOD_W  = 24
) (
    input logic             clk_in,
    input logic             rst_n,
    clk_freq_meter_if.slave bus
);
    localparam int GATE_CYCLES = REF_FREQ / GATE_RATE;
    localparam int GATE_W      = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int HZ_W        = COUNT_W + $clog2(GATE_RATE + 1);

    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]  CNT_MAX   = {COUNT_W{1'b1}};
    localparam logic [PERIOD_W-1:0] PCNT_MAX  = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] PCNT_PRE  = PCNT_MAX - PERIOD_W'(1);
    localparam logic [HZ_W-1:0]     RATE      = HZ_W'(GATE_RATE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    function automatic logic [PERIOD_W-1:0] pcnt_inc(input logic [PERIOD_W-1:0] v);
        return (v == PCNT_MAX) ? v : v + PERIOD_W'(1);
    endfunction

    logic                s1_r, s2_r, s3_r;
    logic [GATE_W-1:0]   gate_cnt_r;
    logic [COUNT_W-1:0]  edge_cnt_r;
    logic                ovf_r;
    logic [COUNT_W-1:0]  freq_count_r;
    logic [HZ_W-1:0]     freq_hz_r;
    logic                freq_valid_r;
    logic                freq_ovf_r;
    logic [PERIOD_W-1:0] pcnt_r;
    state_t              state_r;
    logic [PERIOD_W-1:0] period_cycles_r;
    logic                period_valid_r;
    logic                signal_lost_r;

    logic                edge_s;
    logic                cnt_sat_s;
    logic [COUNT_W-1:0]  cnt_next_s;
    logic                terminal_s;

    // Two-flop synchronizer plus history flop; runs regardless of en
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= bus.sig_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Edge detect and saturating next edge count for the current window
    always_comb begin
        edge_s     = s2_r & ~s3_r;
        cnt_sat_s  = edge_s & (edge_cnt_r == CNT_MAX);
        terminal_s = (gate_cnt_r == GATE_LAST);
        cnt_next_s = edge_cnt_r;
        if (edge_s && !cnt_sat_s) begin
            cnt_next_s = edge_cnt_r + COUNT_W'(1);
        end else begin
            cnt_next_s = edge_cnt_r;
        end
    end

    // Gate window: edges counted until the terminal cycle, which publishes and clears
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_r   <= '0;
            edge_cnt_r   <= '0;
            ovf_r        <= 1'b0;
            freq_count_r <= '0;
            freq_hz_r    <= '0;
            freq_valid_r <= 1'b0;
            freq_ovf_r   <= 1'b0;
        end else if (!bus.en) begin
            gate_cnt_r   <= '0;
            edge_cnt_r   <= '0;
            ovf_r        <= 1'b0;
            freq_valid_r <= 1'b0;
        end else if (terminal_s) begin
            gate_cnt_r   <= '0;
            edge_cnt_r   <= '0;
            ovf_r        <= 1'b0;
            freq_count_r <= cnt_next_s;
            freq_hz_r    <= HZ_W'(cnt_next_s) * RATE;
            freq_ovf_r   <= ovf_r | cnt_sat_s;
            freq_valid_r <= 1'b1;
        end else begin
            gate_cnt_r   <= gate_cnt_r + GATE_W'(1);
            edge_cnt_r   <= cnt_next_s;
            ovf_r        <= ovf_r | cnt_sat_s;
            freq_valid_r <= 1'b0;
        end
    end

    // Period FSM; an edge always wins over a simultaneous pcnt saturation
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r          <= '0;
            state_r         <= ST_IDLE;
            period_cycles_r <= '0;
            period_valid_r  <= 1'b0;
            signal_lost_r   <= 1'b0;
        end else if (!bus.en) begin
            pcnt_r         <= '0;
            state_r        <= ST_IDLE;
            period_valid_r <= 1'b0;
        end else if (edge_s) begin
            pcnt_r  <= PERIOD_W'(1);
            state_r <= ST_ARMED;
            case (state_r)
                ST_ARMED: begin
                    period_cycles_r <= pcnt_r;
                    period_valid_r  <= 1'b1;
                end
                ST_LOST: begin
                    signal_lost_r  <= 1'b0;
                    period_valid_r <= 1'b0;
                end
                default: period_valid_r <= 1'b0;
            endcase
        end else begin
            pcnt_r         <= pcnt_inc(pcnt_r);
            period_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ARMED: begin
                    if (pcnt_r == PCNT_PRE) begin
                        state_r       <= ST_LOST;
                        signal_lost_r <= 1'b1;
                    end
                end
                ST_LOST: state_r <= ST_LOST;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.freq_count    = freq_count_r;
    assign bus.freq_hz       = freq_hz_r;
    assign bus.freq_valid    = freq_valid_r;
    assign bus.freq_ovf      = freq_ovf_r;
    assign bus.period_cycles = period_cycles_r;
    assign bus.period_valid  = period_valid_r;
    assign bus.signal_lost   = signal_lost_r;
endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: REF_FREQ=1000, GATE_RATE=10 (100-cycle windows),
// COUNT_W=4 and PERIOD_W=8 so overflow and signal loss are reachable quickly.
module tb_clk_freq_meter;
    logic clk_in;
    logic rst_n;

    clk_freq_meter_if #(.COUNT_W(4), .PERIOD_W(8), .GATE_RATE(10)) bus ();

    clk_freq_meter #(
        .REF_FREQ (1000),
        .GATE_RATE(10),
        .COUNT_W  (4),
        .PERIOD_W (8)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int         half;
        logic [3:0] cnt;
        logic [7:0] hz;
        logic       ovf;
        logic [7:0] per;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   half  = 0;
    int   ph    = 0;
    logic sig_drv = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One reference cycle; sig_in toggles every `half` cycles when half > 0
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (half > 0) begin
            ph++;
            if (ph >= half) begin
                ph = 0;
                sig_drv = ~sig_drv;
            end
        end
        bus.sig_in = sig_drv;
    endtask

    task automatic wait_fv(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.freq_valid) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fv_timeout: no freq_valid within %0d cycles, required one", max);
        end
    endtask

    function automatic longint all_out();
        return {bus.freq_count, bus.freq_hz, bus.freq_valid, bus.freq_ovf,
                bus.period_cycles, bus.period_valid, bus.signal_lost};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int npv;
        int hold_bad;
        int strb;
        int first_fv;
        int first_pv;
        int first_per;
        int lost_at;

        vecs[0] = '{half: 5,  cnt: 4'd10, hz: 8'd100, ovf: 1'b0, per: 8'd10};
        vecs[1] = '{half: 1,  cnt: 4'd15, hz: 8'd150, ovf: 1'b1, per: 8'd2};
        vecs[2] = '{half: 10, cnt: 4'd5,  hz: 8'd50,  ovf: 1'b0, per: 8'd20};
        vecs[3] = '{half: 2,  cnt: 4'd15, hz: 8'd150, ovf: 1'b1, per: 8'd4};
        vecs[4] = '{half: 25, cnt: 4'd2,  hz: 8'd20,  ovf: 1'b0, per: 8'd50};
        vecs[5] = '{half: 50, cnt: 4'd1,  hz: 8'd10,  ovf: 1'b0, per: 8'd100};
        vecs[6] = '{half: 5,  cnt: 4'd10, hz: 8'd100, ovf: 1'b0, per: 8'd10};

        // Reset and idle with en low
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.sig_in = 1'b0;
        tick();
        tick();
        check("reset_outputs", all_out(), 0);
        rst_n = 1'b1;
        half = 5;
        ph = 0;
        for (int i = 0; i < 40; i++) tick();
        check("en_low_outputs", all_out(), 0);

        // First window after enable, then steady period strobes
        bus.en = 1'b1;
        wait_fv(150, n);
        check("first_fv_latency", n, 100);
        check("first_cnt_9_or_10", (bus.freq_count == 4'd9 || bus.freq_count == 4'd10), 1);
        npv = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.period_valid) npv++;
        end
        check("period_strobes_per_100", npv, 10);
        check("period_value", bus.period_cycles, 10);

        // Table of input periods, checked on the fourth window after each change
        for (int v = 0; v < 7; v++) begin
            half = vecs[v].half;
            ph = 0;
            for (int w = 0; w < 4; w++) wait_fv(120, n);
            check($sformatf("tbl%0d_cnt", v), bus.freq_count, vecs[v].cnt);
            check($sformatf("tbl%0d_hz", v), bus.freq_hz, vecs[v].hz);
            check($sformatf("tbl%0d_ovf", v), bus.freq_ovf, vecs[v].ovf);
            check($sformatf("tbl%0d_per", v), bus.period_cycles, vecs[v].per);
            check($sformatf("tbl%0d_lost", v), bus.signal_lost, 0);
        end

        // Reset mid-window at gate=50
        for (int i = 0; i < 50; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_async_zero", all_out(), 0);
        tick();
        tick();
        check("midreset_held_zero", all_out(), 0);
        rst_n = 1'b1;
        wait_fv(150, n);
        check("midreset_fv_latency", n, 100);

        // Enable drop for 30 cycles at gate=40
        wait_fv(120, n);
        wait_fv(120, n);
        for (int i = 0; i < 40; i++) tick();
        bus.en = 1'b0;
        hold_bad = 0;
        strb = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.freq_valid || bus.period_valid) strb++;
            if (bus.freq_count != 4'd10 || bus.freq_hz != 8'd100 || bus.freq_ovf != 1'b0 ||
                bus.period_cycles != 8'd10 || bus.signal_lost != 1'b0) hold_bad++;
        end
        check("en_drop_strobes", strb, 0);
        check("en_drop_hold", hold_bad, 0);
        bus.en = 1'b1;
        first_fv = -1;
        first_pv = -1;
        first_per = -1;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (bus.period_valid && first_pv < 0) begin
                first_pv = i;
                first_per = int'(bus.period_cycles);
            end
            if (bus.freq_valid && first_fv < 0) first_fv = i;
            if (first_fv >= 0 && first_pv >= 0) break;
        end
        check("reen_fv_latency", first_fv, 100);
        check("reen_first_pv_after_2nd_edge", (first_pv > 10), 1);
        check("reen_first_period", first_per, 10);

        // Single rise detected on the terminal gate cycle
        half = 0;
        sig_drv = 1'b0;
        bus.sig_in = 1'b0;
        for (int w = 0; w < 3; w++) wait_fv(120, n);
        check("term_drained", bus.freq_count, 0);
        for (int i = 0; i < 97; i++) tick();
        sig_drv = 1'b1;
        bus.sig_in = 1'b1;
        tick();
        tick();
        tick();
        check("term_fv", bus.freq_valid, 1);
        check("term_cnt_closing", bus.freq_count, 1);
        wait_fv(120, n);
        check("term_next_latency", n, 100);
        check("term_cnt_next", bus.freq_count, 0);

        // Loss after one edge, then recovery at period 10
        sig_drv = 1'b0;
        bus.sig_in = 1'b0;
        tick();
        tick();
        sig_drv = 1'b1;
        bus.sig_in = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 253; i++) tick();
        check("lost_not_yet", bus.signal_lost, 0);
        tick();
        check("lost_at_254", bus.signal_lost, 1);
        half = 5;
        ph = 0;
        lost_at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!bus.signal_lost) begin
                lost_at = i;
                break;
            end
        end
        check("recover_cleared", (lost_at > 0), 1);
        check("recover_no_strobe", bus.period_valid, 0);
        first_pv = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.period_valid) begin
                first_pv = i;
                break;
            end
        end
        check("recover_pv_spacing", first_pv, 10);
        check("recover_period", bus.period_cycles, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
